// File: rtl/addr_xlat_tlb_if.sv
// ---------------------------------------------------------------------------
// addr_xlat_tlb_if
// Bundles the pipeline-side and TLB-maintenance signals of addr_xlat_tlb.
//   master : pipeline / CP0 side (drives requests and TLB writes/probes)
//   slave  : the translation unit itself
// Channels:
//   inst_* : instruction-fetch lookup (en, req, vaddr -> valid, paddr,
//            uncached, miss)
//   data_* : data-access lookup (adds wr -> mod)
//   tlb_*  : entry write port, probe port and replacement index
// ---------------------------------------------------------------------------
interface addr_xlat_tlb_if #(
  parameter int ENTRIES    = 8,
  parameter int PAGE_SHIFT = 12
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int VPN_W = 32 - PAGE_SHIFT;

  // Instruction channel
  logic             inst_en;
  logic             inst_req;
  logic [31:0]      inst_vaddr;
  logic             inst_valid;
  logic [31:0]      inst_paddr;
  logic             inst_uncached;
  logic             inst_miss;

  // Data channel
  logic             data_en;
  logic             data_req;
  logic [31:0]      data_vaddr;
  logic             data_wr;
  logic             data_valid;
  logic [31:0]      data_paddr;
  logic             data_uncached;
  logic             data_miss;
  logic             data_mod;

  // TLB maintenance
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_idx;
  logic [VPN_W-1:0] tlb_vpn;
  logic [VPN_W-1:0] tlb_pfn;
  logic             tlb_v;
  logic             tlb_d;
  logic             tlb_c;
  logic             tlb_probe;
  logic [VPN_W-1:0] tlb_probe_vpn;
  logic             tlb_probe_done;
  logic             tlb_probe_hit;
  logic [IDX_W-1:0] tlb_probe_idx;
  logic [IDX_W-1:0] tlb_rand_idx;

  modport master (
    output inst_en, inst_req, inst_vaddr,
    input  inst_valid, inst_paddr, inst_uncached, inst_miss,
    output data_en, data_req, data_vaddr, data_wr,
    input  data_valid, data_paddr, data_uncached, data_miss, data_mod,
    output tlb_we, tlb_idx, tlb_vpn, tlb_pfn, tlb_v, tlb_d, tlb_c,
    output tlb_probe, tlb_probe_vpn,
    input  tlb_probe_done, tlb_probe_hit, tlb_probe_idx, tlb_rand_idx
  );

  modport slave (
    input  inst_en, inst_req, inst_vaddr,
    output inst_valid, inst_paddr, inst_uncached, inst_miss,
    input  data_en, data_req, data_vaddr, data_wr,
    output data_valid, data_paddr, data_uncached, data_miss, data_mod,
    input  tlb_we, tlb_idx, tlb_vpn, tlb_pfn, tlb_v, tlb_d, tlb_c,
    input  tlb_probe, tlb_probe_vpn,
    output tlb_probe_done, tlb_probe_hit, tlb_probe_idx, tlb_rand_idx
  );
endinterface

// File: rtl/addr_xlat_tlb.sv
// ---------------------------------------------------------------------------
// addr_xlat_tlb
// MIPS-style address translation for the instruction and data channels.
// kseg0/kseg1 are translated by stripping the segment bits; kuseg and
// kseg2/3 go through a fully associative, software-loaded TLB.
// Results are registered (one cycle latency) and hold while a channel's
// en is low.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : addr_xlat_tlb_if.slave (lookup channels, TLB write, probe,
//            replacement index)
// The TLB has three read ports (inst, data, probe) and one write port;
// all reads see the contents from before a same-cycle write.
// ---------------------------------------------------------------------------
module addr_xlat_tlb #(
  parameter int ENTRIES      = 8,
  parameter int PAGE_SHIFT   = 12,
  parameter bit USE_TLB      = 1'b1,
  parameter bit KSEG0_CACHED = 1'b1
) (
  input logic            clk,
  input logic            resetn,
  addr_xlat_tlb_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int VPN_W = 32 - PAGE_SHIFT;

  typedef logic [ENTRIES-1:0][VPN_W-1:0] tab_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } hit_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        miss;
  } xlat_t;

  tab_t             vpn_q;
  tab_t             pfn_q;
  logic [ENTRIES-1:0] v_q;
  logic [ENTRIES-1:0] d_q;
  logic [ENTRIES-1:0] c_q;
  logic [IDX_W-1:0] rand_q;

  hit_t  inst_hit;
  hit_t  data_hit;
  hit_t  probe_hit;
  xlat_t inst_x;
  xlat_t data_x;
  logic  data_mod_d;

  // Associative match; scanning downwards lets the lowest matching index
  // overwrite any higher one.
  function automatic hit_t lookup(input logic [VPN_W-1:0] tag,
                                  input tab_t tags,
                                  input logic [ENTRIES-1:0] valid);
    hit_t r;
    r = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == tag) begin
        r.hit = 1'b1;
        r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction

  // kseg0 = 100, kseg1 = 101; everything else is mapped.
  function automatic logic is_mapped(input logic [31:0] va);
    return va[31:30] != 2'b10;
  endfunction

  function automatic xlat_t translate(input logic [31:0] va,
                                      input hit_t h,
                                      input tab_t pfns,
                                      input logic [ENTRIES-1:0] cbits);
    xlat_t r;
    r.paddr    = va;
    r.uncached = 1'b0;
    r.miss     = 1'b0;
    if (!is_mapped(va)) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = va[29] ? 1'b1 : !KSEG0_CACHED;
    end else if (USE_TLB) begin
      if (h.hit) begin
        r.paddr    = {pfns[h.idx], va[PAGE_SHIFT-1:0]};
        r.uncached = !cbits[h.idx];
      end else begin
        // Refill/invalid: pass the address through as uncached.
        r.miss     = 1'b1;
        r.uncached = 1'b1;
      end
    end
    return r;
  endfunction

  // NOTE: every variable assigned in always_comb is fully assigned on every
  // path (here via functions that start from defaults), so no latch is inferred.
  always_comb begin
    inst_hit   = lookup(bus.inst_vaddr[31:PAGE_SHIFT], vpn_q, v_q);
    data_hit   = lookup(bus.data_vaddr[31:PAGE_SHIFT], vpn_q, v_q);
    probe_hit  = lookup(bus.tlb_probe_vpn, vpn_q, v_q);
    inst_x     = translate(bus.inst_vaddr, inst_hit, pfn_q, c_q);
    data_x     = translate(bus.data_vaddr, data_hit, pfn_q, c_q);
    // A miss has no hitting entry, so mod and miss are mutually exclusive.
    data_mod_d = USE_TLB && bus.data_wr && is_mapped(bus.data_vaddr) &&
                 data_hit.hit && !d_q[data_hit.idx];
  end

  // NOTE: only the valid bits are reset; tag, frame and attribute bits are
  // ignored while V=0, so that storage is left without a reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q <= '0;
    end else if (bus.tlb_we) begin
      v_q[bus.tlb_idx] <= bus.tlb_v;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.tlb_we) begin
      vpn_q[bus.tlb_idx] <= bus.tlb_vpn;
      pfn_q[bus.tlb_idx] <= bus.tlb_pfn;
      d_q[bus.tlb_idx]   <= bus.tlb_d;
      c_q[bus.tlb_idx]   <= bus.tlb_c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what gives reads the pre-write contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.inst_valid    <= 1'b0;
      bus.inst_paddr    <= '0;
      bus.inst_uncached <= 1'b0;
      bus.inst_miss     <= 1'b0;
    end else if (bus.inst_en) begin
      bus.inst_valid    <= bus.inst_req;
      bus.inst_paddr    <= bus.inst_req ? inst_x.paddr : '0;
      bus.inst_uncached <= bus.inst_req && inst_x.uncached;
      bus.inst_miss     <= bus.inst_req && inst_x.miss;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.data_valid    <= 1'b0;
      bus.data_paddr    <= '0;
      bus.data_uncached <= 1'b0;
      bus.data_miss     <= 1'b0;
      bus.data_mod      <= 1'b0;
    end else if (bus.data_en) begin
      bus.data_valid    <= bus.data_req;
      bus.data_paddr    <= bus.data_req ? data_x.paddr : '0;
      bus.data_uncached <= bus.data_req && data_x.uncached;
      bus.data_miss     <= bus.data_req && data_x.miss;
      bus.data_mod      <= bus.data_req && data_mod_d;
    end
  end

  // Probe result is a one-cycle pulse; idx reads 0 whenever there is no hit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.tlb_probe_done <= 1'b0;
      bus.tlb_probe_hit  <= 1'b0;
      bus.tlb_probe_idx  <= '0;
    end else begin
      bus.tlb_probe_done <= bus.tlb_probe;
      bus.tlb_probe_hit  <= bus.tlb_probe && probe_hit.hit;
      bus.tlb_probe_idx  <= (bus.tlb_probe && probe_hit.hit) ? probe_hit.idx : '0;
    end
  end

  // Free-running replacement index. ENTRIES is a power of two, so the
  // natural wrap of the decrement goes from 0 to ENTRIES-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rand_q <= IDX_W'(ENTRIES - 1);
    end else begin
      rand_q <= rand_q - IDX_W'(1);
    end
  end

  assign bus.tlb_rand_idx = rand_q;

endmodule
